framebuffer_stream_writer: RTL and testbench
============================================

# framebuffer_stream_writer

Parametrised pixel-stream packer between the UART receiver and the framebuffer write port. Accepts one byte per `rx_data_ready` strobe, unpacks it into `8/BPP` pixels, packs pixels into `WORD_W`-bit framebuffer words, and issues one `write` per full word with the pixel address of that word's first pixel. Raster order with auto-wrap: rows, then frames. Adds an optional sync-byte frame start, an inter-byte timeout abort and a frame counter.

## Interface
- `H_RES`, 640, pixels per row
- `V_RES`, 480, rows per frame
- `BPP`, 4, bits per pixel; legal 1, 2, 4, 8
- `WORD_W`, 32, framebuffer word width; multiple of 8, `H_RES % (WORD_W/BPP) == 0`
- `ADDR_W`, 10, width of `addr_x` and `addr_y`
- `SYNC_EN`, 0, 1 = frame starts only after byte `SYNC_BYTE`
- `SYNC_BYTE`, 8'hA5, frame-start marker
- `TIMEOUT_CYC`, 0, idle cycles mid-frame before abort; 0 = disabled

One clock; reset is synchronous and active-high.

- `clk` in 1 — system clock
- `reset` in 1 — synchronous, active-high
- `data_in` in 8 — received byte, valid with `rx_data_ready`
- `rx_data_ready` in 1 — byte strobe; every cycle high = one byte
- `addr_x` out ADDR_W — pixel x of first pixel in `data_out`
- `addr_y` out ADDR_W — row of `data_out`
- `data_out` out WORD_W — packed pixels
- `write` out 1 — one-cycle write strobe
- `done_recieving` out 1 — high from last write of a frame until the first byte of the next frame
- `frame_error` out 1 — one-cycle pulse on timeout abort
- `frame_count` out 8 — completed frames, wraps 255→0

## Operation
- `PPB = 8/BPP` pixels per byte; `PPW = WORD_W/BPP` pixels per word; `BPW = WORD_W/8` bytes per word.
- Byte unpack: MSB-first, first pixel = `data_in[7:8-BPP]`.
- Word pack: first pixel at `data_out[BPP-1:0]`, later pixels at increasing bit positions. For BPP=4, bytes 0x12,0x34,0x56,0x78 → 0x87654321.
- Byte counter 0..BPW-1 inside the shift register; on the BPW-th byte, word is emitted and the counter clears.
- Word address: x advances by PPW per word; after x = H_RES−PPW, x→0 and y++. After the word at (H_RES−PPW, V_RES−1), frame completes: x,y→0, `frame_count`++, enter DONE.
- States:
  - WAIT_SYNC: only when SYNC_EN=1. Bytes ≠ SYNC_BYTE discarded; SYNC_BYTE → RECV (the sync byte is not pixel data).
  - RECV: bytes packed as above. SYNC_BYTE in RECV is ordinary data (no escaping).
  - DONE: `done_recieving`=1. SYNC_EN=0: next byte is the first pixel byte of the next frame → RECV, `done_recieving` drops. SYNC_EN=1: → WAIT_SYNC behaviour; `done_recieving` drops on sync byte acceptance.
- Reset state: WAIT_SYNC if SYNC_EN=1, else RECV with zero bytes accepted.
- Timeout: counter runs in RECV only after at least one byte of the current frame is accepted; cleared on every accepted byte. Reaching TIMEOUT_CYC: discard partial word, x,y→0, pulse `frame_error`, go to reset state. `frame_count` unchanged; no `write`.
- Reset mid-frame discards the partial word and all position state; `frame_count`→0.

## Timing
- Reset values: `addr_x`=0, `addr_y`=0, `data_out`=0, `write`=0, `done_recieving`=0, `frame_error`=0, `frame_count`=0.
- Byte accepted on rising edge with `rx_data_ready`=1; no backpressure; downstream always accepts.
- `write`, `addr_x`, `addr_y` and `data_out` are registered. They are valid in the cycle after the edge that accepts the completing byte. `write` lasts exactly 1 cycle; `data_out`/address hold until the next write.
- `done_recieving` and `frame_count` update in the same cycle as the final frame `write`.
- Back-to-back strobes (every cycle) are supported at full rate. A byte accepted during a `write` cycle is packed normally.
- `frame_error` is asserted the cycle after the count reaches TIMEOUT_CYC. A byte arriving on that same edge wins: the counter clears and there is no abort.

## Test plan
- Defaults; bytes 0x12,0x34,0x56,0x78 → single `write` 1 cycle after 4th byte, `data_out`=0x87654321, `addr_x`=0, `addr_y`=0.
- Defaults; 320 random bytes → 80 writes, `addr_x`=0,8,…,632, `addr_y`=0. The next 4 bytes → write at (0,1). `data_out` matches reference model.
- Defaults; 2 frames of 153600 bytes each, 1 strobe per 10 cycles → last write at (632,479). `done_recieving` rises with it, `frame_count`=1. `done_recieving` falls on next byte; after frame 2, `frame_count`=2.
- TIMEOUT_CYC=1000; 2 bytes then idle → `frame_error` pulse ~1000 cycles later, no `write`. The next 4 bytes 0x11,0x22,0x33,0x44 → write 0x44332211 at (0,0).
- SYNC_EN=1, H_RES=8, V_RES=2, BPP=8, WORD_W=16; bytes 0x00,0x5A ignored, then 0xA5, then 16 bytes → 8 writes, addr_x 0,2,4,6 for each row. Reset asserted after 5 data bytes → all outputs 0, WAIT_SYNC.
- BPP=1, WORD_W=8, H_RES=16, V_RES=1; 2 back-to-back bytes 0x80,0x01 → writes 0x01 at x=0, 0x80 at x=8, `done_recieving`=1.

Source files
------------

// File: rtl/framebuffer_stream_writer.sv
// framebuffer_stream_writer: unpacks UART bytes into pixels and writes raster-addressed framebuffer words
module framebuffer_stream_writer #(
    parameter int         H_RES       = 640,
    parameter int         V_RES       = 480,
    parameter int         BPP         = 4,
    parameter int         WORD_W      = 32,
    parameter int         ADDR_W      = 10,
    parameter int         SYNC_EN     = 0,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        data_in,
    input  logic              rx_data_ready,
    output logic [ADDR_W-1:0] addr_x,
    output logic [ADDR_W-1:0] addr_y,
    output logic [WORD_W-1:0] data_out,
    output logic              write,
    output logic              done_recieving,
    output logic              frame_error,
    output logic [7:0]        frame_count
);
    localparam int PPB = 8 / BPP;
    localparam int PPW = WORD_W / BPP;
    localparam int BPW = WORD_W / 8;
    localparam int CNT_W = BPW > 1 ? $clog2(BPW) : 1;
    localparam int TO_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BPW - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(H_RES - PPW);
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] X_STEP   = ADDR_W'(PPW);

    typedef enum logic [1:0] {S_WAIT_SYNC, S_RECV, S_DONE} state_t;
    localparam state_t S_IDLE = SYNC_EN != 0 ? S_WAIT_SYNC : S_RECV;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              started_q, started_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [ADDR_W-1:0] x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              write_q, write_d, done_q, done_d, frame_error_q, frame_error_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic [7:0]        rev;
    logic              pack, sync_hit;

    always_comb begin
        rev = '0;
        // first (most significant) pixel of the byte lands at the lowest pixel slot
        for (int j = 0; j < PPB; j++) rev[j*BPP +: BPP] = data_in[8-(j+1)*BPP +: BPP];
        pack = rx_data_ready && (state_q == S_RECV || (state_q == S_DONE && SYNC_EN == 0));
        sync_hit = rx_data_ready && state_q != S_RECV && SYNC_EN != 0 && data_in == SYNC_BYTE;
        state_d = state_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d = to_cnt_q;
        started_d = started_q;
        sr_d = sr_q;
        x_d = x_q;
        y_d = y_q;
        addr_x_d = addr_x_q;
        addr_y_d = addr_y_q;
        data_out_d = data_out_q;
        write_d = 1'b0;
        done_d = done_q;
        frame_error_d = 1'b0;
        frame_count_d = frame_count_q;
        if (sync_hit) begin
            state_d = S_RECV;
            done_d = 1'b0;
        end
        if (pack) begin
            state_d = S_RECV;
            done_d = 1'b0;
            started_d = 1'b1;
            to_cnt_d = '0;
            sr_d[{byte_cnt_q, 3'b000} +: 8] = rev;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == CNT_LAST) begin
                byte_cnt_d = '0;
                write_d = 1'b1;
                data_out_d = sr_d;
                addr_x_d = x_q;
                addr_y_d = y_q;
                x_d = x_q + X_STEP;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                    if (y_q == Y_LAST) begin
                        y_d = '0;
                        frame_count_d = frame_count_q + 8'd1;
                        done_d = 1'b1;
                        started_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
        end else if (TIMEOUT_CYC != 0 && state_q == S_RECV && started_q) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) begin
                to_cnt_d = '0;
                byte_cnt_d = '0;
                started_d = 1'b0;
                x_d = '0;
                y_d = '0;
                frame_error_d = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            byte_cnt_q <= '0;
            to_cnt_q <= '0;
            started_q <= 1'b0;
            sr_q <= '0;
            x_q <= '0;
            y_q <= '0;
            addr_x_q <= '0;
            addr_y_q <= '0;
            data_out_q <= '0;
            write_q <= 1'b0;
            done_q <= 1'b0;
            frame_error_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q <= state_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q <= to_cnt_d;
            started_q <= started_d;
            sr_q <= sr_d;
            x_q <= x_d;
            y_q <= y_d;
            addr_x_q <= addr_x_d;
            addr_y_q <= addr_y_d;
            data_out_q <= data_out_d;
            write_q <= write_d;
            done_q <= done_d;
            frame_error_q <= frame_error_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign addr_x = addr_x_q;
    assign addr_y = addr_y_q;
    assign data_out = data_out_q;
    assign write = write_q;
    assign done_recieving = done_q;
    assign frame_error = frame_error_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_framebuffer_stream_writer.sv
// tb_framebuffer_stream_writer: scoreboard bench over three parameterisations of the stream writer
module tb_framebuffer_stream_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [9:0] ax0, ay0, ax1, ay1, ax2, ay2;
    logic [31:0] do0;
    logic [15:0] do1;
    logic [7:0] do2;
    logic w0, w1, w2, dn0, dn1, dn2, fe0, fe1, fe2;
    logic [7:0] fc0, fc1, fc2;

    framebuffer_stream_writer #(.TIMEOUT_CYC(1000)) u0 (
        .clk(clk), .reset(rst0), .data_in(d0), .rx_data_ready(r0), .addr_x(ax0), .addr_y(ay0),
        .data_out(do0), .write(w0), .done_recieving(dn0), .frame_error(fe0), .frame_count(fc0));
    framebuffer_stream_writer #(.H_RES(8), .V_RES(2), .BPP(8), .WORD_W(16), .SYNC_EN(1)) u1 (
        .clk(clk), .reset(rst1), .data_in(d1), .rx_data_ready(r1), .addr_x(ax1), .addr_y(ay1),
        .data_out(do1), .write(w1), .done_recieving(dn1), .frame_error(fe1), .frame_count(fc1));
    framebuffer_stream_writer #(.H_RES(16), .V_RES(1), .BPP(1), .WORD_W(8)) u2 (
        .clk(clk), .reset(rst2), .data_in(d2), .rx_data_ready(r2), .addr_x(ax2), .addr_y(ay2),
        .data_out(do2), .write(w2), .done_recieving(dn2), .frame_error(fe2), .frame_count(fc2));

    typedef struct {
        logic [31:0] x, y, d;
        logic        dn;
        logic [7:0]  fc;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int u, input int x, input int y, input logic [31:0] d, input logic dn, input logic [7:0] fc);
        exp_t e;
        e.x = x; e.y = y; e.d = d; e.dn = dn; e.fc = fc;
        case (u)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int u, input logic [31:0] x, input logic [31:0] y, input logic [31:0] d, input logic dn, input logic [7:0] fc);
        exp_t e;
        int n;
        n = u == 0 ? q0.size() : u == 1 ? q1.size() : q2.size();
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write u%0d: got x=%0d y=%0d data=%0h, required no write", u, x, y, d);
        end else begin
            case (u)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("u%0d_addr_x", u), x, e.x);
            chk($sformatf("u%0d_addr_y", u), y, e.y);
            chk($sformatf("u%0d_data", u), d, e.d);
            chk($sformatf("u%0d_done", u), {31'd0, dn}, {31'd0, e.dn});
            chk($sformatf("u%0d_frame_count", u), {24'd0, fc}, {24'd0, e.fc});
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (w0) mon(0, {22'd0, ax0}, {22'd0, ay0}, do0, dn0, fc0);
        if (w1) mon(1, {22'd0, ax1}, {22'd0, ay1}, {16'd0, do1}, dn1, fc1);
        if (w2) mon(2, {22'd0, ax2}, {22'd0, ay2}, {24'd0, do2}, dn2, fc2);
    end

    task automatic send(input int u, input logic [7:0] b);
        @(negedge clk);
        case (u)
            0: begin d0 = b; r0 = 1'b1; end
            1: begin d1 = b; r1 = 1'b1; end
            default: begin d2 = b; r2 = 1'b1; end
        endcase
    endtask

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r0 = u == 0 ? 1'b0 : r0;
            r1 = u == 1 ? 1'b0 : r1;
            r2 = u == 2 ? 1'b0 : r2;
        end
    endtask

    task automatic do_reset(input int u);
        @(negedge clk);
        rst0 = u == 0 ? 1'b1 : rst0;
        rst1 = u == 1 ? 1'b1 : rst1;
        rst2 = u == 2 ? 1'b1 : rst2;
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        repeat (2) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    endtask

    function automatic logic [7:0] pat0(input int i);
        return 8'(i * 37 + 5);
    endfunction

    initial begin
        logic [31:0] w;
        logic [7:0] b;
        int cyc;
        logic seen;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        chk("rst_addr_x", {22'd0, ax0}, 0);
        chk("rst_addr_y", {22'd0, ay0}, 0);
        chk("rst_data_out", do0, 0);
        chk("rst_write", {31'd0, w0}, 0);
        chk("rst_done", {31'd0, dn0}, 0);
        chk("rst_frame_error", {31'd0, fe0}, 0);
        chk("rst_frame_count", {24'd0, fc0}, 0);

        // BPP=4 single word
        push(0, 0, 0, 32'h87654321, 1'b0, 8'd0);
        send(0, 8'h12); send(0, 8'h34); send(0, 8'h56); send(0, 8'h78);
        idle(0, 4);

        // one full row at full rate, then first word of row 1
        do_reset(0);
        for (int k = 0; k < 81; k++) begin
            w = '0;
            for (int p = 0; p < 4; p++) begin
                b = pat0(4 * k + p);
                w[p*8 +: 8] = {b[3:0], b[7:4]};
            end
            push(0, k < 80 ? 8 * k : 0, k < 80 ? 0 : 1, w, 1'b0, 8'd0);
        end
        for (int i = 0; i < 324; i++) send(0, pat0(i));
        idle(0, 4);

        // inter-byte timeout: abort exactly 1000 idle edges after the 2nd byte
        do_reset(0);
        send(0, 8'hDE); send(0, 8'hAD);
        idle(0, 1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 1100) begin
            @(posedge clk); #1;
            cyc++;
            seen = fe0;
        end
        chk("timeout_seen", {31'd0, seen}, 1);
        chk("timeout_cycles", cyc, 1000);
        @(posedge clk); #1;
        chk("timeout_pulse_width", {31'd0, fe0}, 0);
        chk("timeout_frame_count", {24'd0, fc0}, 0);
        push(0, 0, 0, 32'h44332211, 1'b0, 8'd0);
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
        idle(0, 4);

        // sync-gated frame, BPP=8, 16-bit words; 0xA5 inside the frame is plain data
        send(1, 8'h00); send(1, 8'h5A); send(1, 8'hA5);
        for (int k = 0; k < 8; k++)
            push(1, 2 * (k % 4), k / 4, {16'd0, (2*k+1 == 3 ? 8'hA5 : 8'(8'h40 + 2*k+1)), (2*k == 3 ? 8'hA5 : 8'(8'h40 + 2*k))},
                 k == 7, k == 7 ? 8'd1 : 8'd0);
        for (int i = 0; i < 16; i++) send(1, i == 3 ? 8'hA5 : 8'(8'h40 + i));
        idle(1, 3);
        chk("u1_done_hold", {31'd0, dn1}, 1);
        send(1, 8'h77);
        idle(1, 2);
        chk("u1_done_nonsync", {31'd0, dn1}, 1);
        send(1, 8'hA5);
        idle(1, 1);
        chk("u1_done_drop", {31'd0, dn1}, 0);
        push(1, 0, 0, 32'h5150, 1'b0, 8'd1);
        push(1, 2, 0, 32'h5352, 1'b0, 8'd1);
        for (int i = 0; i < 5; i++) send(1, 8'(8'h50 + i));
        idle(1, 3);
        do_reset(1);
        @(negedge clk);
        chk("u1_rst_addr_x", {22'd0, ax1}, 0);
        chk("u1_rst_addr_y", {22'd0, ay1}, 0);
        chk("u1_rst_data", {16'd0, do1}, 0);
        chk("u1_rst_done", {31'd0, dn1}, 0);
        chk("u1_rst_frame_count", {24'd0, fc1}, 0);
        push(1, 0, 0, 32'h6261, 1'b0, 8'd0);
        send(1, 8'h01); send(1, 8'hA5); send(1, 8'h61); send(1, 8'h62);
        idle(1, 4);

        // BPP=1, 8-bit words, 2-byte frames
        push(2, 0, 0, 32'h01, 1'b0, 8'd0);
        push(2, 8, 0, 32'h80, 1'b1, 8'd1);
        send(2, 8'h80); send(2, 8'h01);
        idle(2, 9);
        chk("u2_done_hold", {31'd0, dn2}, 1);
        push(2, 0, 0, 32'hFF, 1'b0, 8'd1);
        push(2, 8, 0, 32'hF0, 1'b1, 8'd2);
        push(2, 0, 0, 32'h05, 1'b0, 8'd2);
        push(2, 8, 0, 32'h00, 1'b1, 8'd3);
        send(2, 8'hFF); idle(2, 9);
        send(2, 8'h0F); idle(2, 9);
        chk("u2_done_after_frame2", {31'd0, dn2}, 1);
        send(2, 8'hA0); send(2, 8'h00);
        idle(2, 4);

        chk("u0_queue_empty", q0.size(), 0);
        chk("u1_queue_empty", q1.size(), 0);
        chk("u2_queue_empty", q2.size(), 0);
        chk("u1_no_frame_error", {31'd0, fe1}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
